// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Bundles the byte-queue side (wr/wd/ovfclr), the transmitter side
// (txbusy/load/d) and the status outputs of uart_tx_fifo.
//   master : drives wr, wd, ovfclr, txbusy; observes load, d, full, empty,
//            count, ovf
//   slave  : the FIFO itself (mirror of master)
// AW must match the AW of the attached uart_tx_fifo.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int AW = 4
) ();
    logic          wr;
    logic [7:0]    wd;
    logic          ovfclr;
    logic          txbusy;
    logic          load;
    logic [7:0]    d;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;

    modport master (
        output wr, wd, ovfclr, txbusy,
        input  load, d, full, empty, count, ovf
    );

    modport slave (
        input  wr, wd, ovfclr, txbusy,
        output load, d, full, empty, count, ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO (2**AW deep) feeding a UART transmitter. A small sequencer pops a
// byte whenever the transmitter is idle, presents it on d and strobes load for
// one cycle, then waits one guard cycle for txbusy to rise.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : uart_tx_fifo_if.slave
//            wr/wd   - enqueue strobe and byte (dropped when full, sets ovf)
//            ovfclr  - clears the sticky overflow flag (a drop wins)
//            txbusy  - transmitter busy, sampled only while idle
//            load/d  - registered one-cycle load strobe and popped byte
//            full/empty/count/ovf - registered status
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int unsigned   DEPTH     = 2**AW;
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic [AW:0]     count;
    logic            load_q;
    logic [7:0]      d_q;
    logic            ovf_q;

    logic            full;
    logic            empty;
    logic            push;
    logic            drop;
    logic            pop;

    // Status comes from the count register only.
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign push  = bus.wr & ~full;
    assign drop  = bus.wr & full;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !bus.txbusy) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD:    state_next = GUARD;
            GUARD:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            load_q <= 1'b0;
            d_q    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_next;
            // load is its own flop so it is glitch-free and high only in LOAD.
            load_q <= (state_next == LOAD);
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp  <= rp + AW'(1);
                d_q <= mem[rp];
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovfclr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; slots are only read after a write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= bus.wd;
        end
    end

    assign bus.load  = load_q;
    assign bus.d     = d_q;
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = count;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Two instances: AW=4 (directed tests, modelled transmitter) and AW=2
// (pointer wrap under random txbusy). Expected bytes are queued when a write
// is driven and compared when load is seen.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    logic clk;
    logic rst_n;

    uart_tx_fifo_if #(.AW(4)) bus4 ();
    uart_tx_fifo_if #(.AW(2)) bus2 ();

    uart_tx_fifo #(.AW(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    uart_tx_fifo #(.AW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0] q4 [$];
    logic [7:0] q2 [$];

    logic man_en4     = 1'b1;
    logic man_busy4   = 1'b0;
    logic model_busy4 = 1'b0;
    int   cnt4        = 0;
    logic rand_en2    = 1'b0;
    logic busy2       = 1'b0;
    logic prev_busy2  = 1'b0;

    assign bus4.txbusy = man_en4 ? man_busy4 : model_busy4;
    assign bus2.txbusy = busy2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain4(input int unsigned limit);
        int unsigned n = 0;
        while (q4.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check("drain4_left", q4.size(), 0);
        repeat (3) tick();
    endtask

    // Monitor + transmitter model, away from the active edge.
    always @(negedge clk) begin
        if (bus4.load) begin
            if (q4.size() == 0) check("load4_unexpected", bus4.load, 1'b0);
            else                check("d4_order", bus4.d, q4.pop_front());
            cnt4 = 11;
        end else if (cnt4 > 0) begin
            cnt4--;
        end
        model_busy4 = (cnt4 > 0);

        if (bus2.load) begin
            check("busy2_before_load", prev_busy2, 1'b0);
            if (q2.size() == 0) check("load2_unexpected", bus2.load, 1'b0);
            else                check("d2_order", bus2.d, q2.pop_front());
        end
        busy2      = rand_en2 ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_busy2 = busy2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned sent;
        logic [7:0]  b;

        rst_n       = 1'b1;
        bus4.wr     = 1'b0; bus4.wd = '0; bus4.ovfclr = 1'b0;
        bus2.wr     = 1'b0; bus2.wd = '0; bus2.ovfclr = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_load",  bus4.load,  1'b0);
        check("rst_d",     bus4.d,     8'h00);
        check("rst_count", bus4.count, 0);
        check("rst_empty", bus4.empty, 1'b1);
        check("rst_full",  bus4.full,  1'b0);
        check("rst_ovf",   bus4.ovf,   1'b0);
        check("rst_empty2", bus2.empty, 1'b1);
        rst_n = 1'b1;
        tick();

        // Single byte latency: wr in cycle 0, load in cycle 2
        man_en4 = 1'b1; man_busy4 = 1'b0;
        bus4.wr = 1'b1; bus4.wd = 8'hA5; q4.push_back(8'hA5);
        tick();
        bus4.wr = 1'b0;
        check("lat_c1_empty", bus4.empty, 1'b0);
        check("lat_c1_count", bus4.count, 1);
        check("lat_c1_load",  bus4.load,  1'b0);
        tick();
        check("lat_c2_load",  bus4.load,  1'b1);
        check("lat_c2_d",     bus4.d,     8'hA5);
        check("lat_c2_count", bus4.count, 0);
        check("lat_c2_empty", bus4.empty, 1'b1);
        tick();
        check("lat_c3_load",  bus4.load,  1'b0);
        check("lat_c3_d_hold", bus4.d,    8'hA5);
        repeat (3) tick();

        // Fill to full with transmitter busy, 17th write dropped
        man_busy4 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus4.wr = 1'b1; bus4.wd = 8'(i);
            if (i < 16) q4.push_back(8'(i));
            tick();
            if (i == 15) begin
                check("fill_full",  bus4.full,  1'b1);
                check("fill_count", bus4.count, 16);
                check("fill_ovf0",  bus4.ovf,   1'b0);
            end
        end
        bus4.wr = 1'b0;
        check("drop_ovf",   bus4.ovf,   1'b1);
        check("drop_count", bus4.count, 16);
        bus4.ovfclr = 1'b1;
        tick();
        bus4.ovfclr = 1'b0;
        check("ovfclr", bus4.ovf, 1'b0);
        // Drop and clear together: set wins
        bus4.wr = 1'b1; bus4.wd = 8'hEE; bus4.ovfclr = 1'b1;
        tick();
        bus4.wr = 1'b0; bus4.ovfclr = 1'b0;
        check("ovf_set_wins", bus4.ovf, 1'b1);
        bus4.ovfclr = 1'b1;
        tick();
        bus4.ovfclr = 1'b0;
        check("ovfclr2", bus4.ovf, 1'b0);

        // Drain through the transmitter model: 0x00..0x0F in order only
        man_en4 = 1'b0;
        drain4(600);
        check("drain_empty", bus4.empty, 1'b1);
        check("drain_count", bus4.count, 0);

        // Pop and write in the same cycle at count=5
        man_en4 = 1'b1; man_busy4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus4.wr = 1'b1; bus4.wd = 8'(8'h40 + i); q4.push_back(8'(8'h40 + i));
            tick();
        end
        check("c5_count", bus4.count, 5);
        man_busy4 = 1'b0;
        bus4.wr = 1'b1; bus4.wd = 8'h55; q4.push_back(8'h55);
        tick();
        bus4.wr = 1'b0;
        check("c5_load",  bus4.load,  1'b1);
        check("c5_count_same", bus4.count, 5);
        man_en4 = 1'b0;
        drain4(400);

        // Wrap through AW=2 with random txbusy
        rand_en2 = 1'b1;
        sent = 0; n = 0;
        while (sent < 40 && n < 3000) begin
            if (!bus2.full) begin
                b = 8'($urandom);
                bus2.wr = 1'b1; bus2.wd = b; q2.push_back(b);
                sent++;
            end else begin
                bus2.wr = 1'b0;
            end
            tick();
            n++;
        end
        bus2.wr = 1'b0;
        check("wrap_sent", sent, 40);
        n = 0;
        while (q2.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check("wrap_left",  q2.size(),  0);
        rand_en2 = 1'b0;
        repeat (4) tick();
        check("wrap_empty", bus2.empty, 1'b1);
        check("wrap_ovf",   bus2.ovf,   1'b0);

        // Reset during LOAD
        man_en4 = 1'b1; man_busy4 = 1'b0;
        bus4.wr = 1'b1; bus4.wd = 8'h3C; q4.push_back(8'h3C);
        tick();
        bus4.wr = 1'b0; bus4.wd = 8'h77;
        q4.push_back(8'h77);
        bus4.wr = 1'b1;
        tick();
        bus4.wr = 1'b0;
        n = 0;
        while (!bus4.load && n < 10) begin
            tick();
            n++;
        end
        check("rl_load_seen", bus4.load, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rl_load_async",  bus4.load,  1'b0);
        check("rl_count_async", bus4.count, 0);
        check("rl_empty_async", bus4.empty, 1'b1);
        q4.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("rl_count_after", bus4.count, 0);
        check("rl_empty_after", bus4.empty, 1'b1);
        check("rl_d_after",     bus4.d,     8'h00);
        repeat (10) tick();
        check("rl_no_load", bus4.load, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter AW, default 4, log2 of FIFO depth; depth = 2**AW bytes, legal range 2..8.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; one clock, asynchronous and active-low.
REQ-004 wr  input  1  write strobe; a byte is offered on every cycle wr=1.
REQ-005 wd  input  8  byte to enqueue, sampled when wr=1.
REQ-006 ovfclr  input  1  clears the sticky overflow flag.
REQ-007 txbusy  input  1  busy status from the downstream UART transmitter.
REQ-008 load  output  1  one-cycle strobe to the transmitter's load input.
REQ-009 d  output  8  byte to the transmitter's d input, valid while load=1.
REQ-010 full  output  1  high when count = 2**AW.
REQ-011 empty  output  1  high when count = 0.
REQ-012 count  output  AW+1  number of bytes stored.
REQ-013 ovf  output  1  sticky flag: a write was dropped.

Function
REQ-014 Storage is a circular buffer of 2**AW x 8 with AW-bit write and read pointers; both pointers wrap from 2**AW-1 to 0.
REQ-015 Write is accepted when wr=1 and full=0: mem[wp]<=wd, wp increments, count increments unless a pop occurs in the same cycle.
REQ-016 When wr=1 and full=1, the byte is dropped and ovf<=1; this holds even if a pop occurs in that cycle.
REQ-017 ovf clears on ovfclr=1; if ovfclr=1 and a drop occur in the same cycle, ovf is 1 afterwards (set wins).
REQ-018 The sequencer FSM has states IDLE, LOAD, GUARD and is registered.
REQ-019 IDLE -> LOAD when empty=0 and txbusy=0. This is the pop: d<=mem[rp], rp increments, count decrements. Otherwise IDLE is held.
REQ-020 LOAD: load=1 for exactly this one cycle; d holds the popped byte. LOAD -> GUARD unconditionally.
REQ-021 GUARD: load=0. GUARD lasts one cycle and covers the transmitter's one-cycle delay before txbusy rises. GUARD -> IDLE unconditionally.
REQ-022 load is a registered output, high only in LOAD; two load pulses are separated by at least 2 cycles.
REQ-023 d is registered and changes only on a pop; it holds its last value otherwise.
REQ-024 A pop and an accepted write in the same cycle leave count unchanged.
REQ-025 Writing into an empty FIFO makes empty=0 on the next cycle. The earliest load occurs 2 cycles after the wr cycle.
REQ-026 full, empty and count reflect registered state only and never depend combinationally on wr or txbusy.
REQ-027 txbusy is sampled only in IDLE; its value in LOAD and GUARD is ignored.
REQ-028 Byte order on d equals write order; no byte is duplicated or skipped.

Reset
REQ-029 When rst_n is low: state=IDLE, wp=rp=0, count=0, empty=1, full=0, ovf=0, load=0, d=8'h00, asynchronously.
REQ-030 Reset in LOAD or GUARD aborts the sequence. load falls immediately, and queued bytes are discarded.
REQ-031 Memory contents are not reset; they are unobservable until written.
REQ-032 After rst_n rises, the first edge behaves as IDLE with an empty FIFO.

Verification
REQ-033 Reset, txbusy=0, wr 8'hA5 at cycle 0 -> load=1 with d=8'hA5 at cycle 2, count back to 0, empty=1.
REQ-034 AW=4, txbusy=1, 17 consecutive writes 0x00..0x10 -> full=1 and count=16 after 16 writes; the 17th write is dropped; ovf=1; ovfclr pulse -> ovf=0.
REQ-035 Continue REQ-034: release txbusy, model the transmitter (txbusy high 1 cycle after load, for 10 cycles) -> bytes 0x00..0x0F appear on d in order, and 0x10 never appears.
REQ-036 FIFO at count=5, txbusy=0, wr=1 on the same cycle as an IDLE->LOAD pop -> count stays 5.
REQ-037 Pointer wrap: 40 bytes through an AW=2 FIFO with random txbusy -> the scoreboard matches all 40 bytes, and no load occurs while txbusy was 1 in the preceding IDLE cycle.
REQ-038 rst_n asserted during LOAD -> load=0 in the same cycle; count=0 and empty=1 after release; no further load until a new write.
